// File: rtl/pipe_exe.sv
// EXE stage of a five-stage MIPS-like pipeline: ALU, HI/LO registers and a
// 32-step restoring divider, with valid/allowin handshaking toward ID and MEM.
`timescale 1ns/1ps

module pipe_exe (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_exe_validto,
  input  logic        mem_allowin,
  input  logic        flush_exe,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  input  logic [15:0] imm_in,
  input  logic [4:0]  rdc_in,
  input  logic [3:0]  aluc_in,
  input  logic        alu_b_sel_in,
  input  logic        rf_we_in,
  input  logic        lw_instr_in,
  output logic        exe_allowin,
  output logic        exe_mem_validto,
  output logic [31:0] pc_out,
  output logic [31:0] alu_out,
  output logic [31:0] rt_out,
  output logic [4:0]  rdc_exe,
  output logic        rf_we_out,
  output logic [31:0] bypass_exe,
  output logic        exe_rdc_valid,
  output logic        exe_lw_instr,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_busy
);

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_MFHI = 4'd9;
  localparam logic [3:0] ALU_MFLO = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_DIVU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  logic        exe_valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] rs_reg;
  logic [31:0] rt_reg;
  logic [15:0] imm_reg;
  logic [4:0]  rdc_reg;
  logic [3:0]  aluc_reg;
  logic        b_sel_reg;
  logic        rf_we_reg;
  logic        lw_reg;

  div_state_t  state_reg;
  div_state_t  state_next;
  logic [4:0]  cnt_reg;
  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] dvs_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic        exe_ready_go;
  logic        is_div;
  logic        div_signed;
  logic        div_start;
  logic        load_payload;
  logic        hilo_write;

  // ---------------------------------------------------------------- handshake
  assign is_div          = (aluc_reg == ALU_DIV) || (aluc_reg == ALU_DIVU);
  assign div_signed      = (aluc_reg == ALU_DIV);
  assign exe_allowin     = !exe_valid_reg || (exe_ready_go && mem_allowin);
  assign exe_mem_validto = exe_valid_reg && exe_ready_go && !flush_exe;
  assign load_payload    = id_exe_validto && exe_allowin && !flush_exe;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid_reg <= 1'b0;
    end else if (flush_exe) begin
      exe_valid_reg <= 1'b0;
    end else if (exe_allowin) begin
      exe_valid_reg <= id_exe_validto;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      imm_reg   <= '0;
      rdc_reg   <= '0;
      aluc_reg  <= '0;
      b_sel_reg <= 1'b0;
      rf_we_reg <= 1'b0;
      lw_reg    <= 1'b0;
    end else if (load_payload) begin
      pc_reg    <= pc_in;
      rs_reg    <= rs_in;
      rt_reg    <= rt_in;
      imm_reg   <= imm_in;
      rdc_reg   <= rdc_in;
      aluc_reg  <= aluc_in;
      b_sel_reg <= alu_b_sel_in;
      rf_we_reg <= rf_we_in;
      lw_reg    <= lw_instr_in;
    end
  end

  // ---------------------------------------------------------------- ALU
  logic [31:0] op_b;
  logic [31:0] and_v;
  logic [31:0] or_v;
  logic [31:0] xor_v;
  logic [31:0] nor_v;

  assign op_b = b_sel_reg ? {{16{imm_reg[15]}}, imm_reg} : rt_reg;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_logic_lane
      assign and_v[gi] = rs_reg[gi] & op_b[gi];
      assign or_v[gi]  = rs_reg[gi] | op_b[gi];
      assign xor_v[gi] = rs_reg[gi] ^ op_b[gi];
      assign nor_v[gi] = ~(rs_reg[gi] | op_b[gi]);
    end
  endgenerate

  always_comb begin
    alu_out = '0;
    case (aluc_reg)
      ALU_ADDU: alu_out = rs_reg + op_b;
      ALU_SUBU: alu_out = rs_reg - op_b;
      ALU_AND:  alu_out = and_v;
      ALU_OR:   alu_out = or_v;
      ALU_XOR:  alu_out = xor_v;
      ALU_NOR:  alu_out = nor_v;
      ALU_SLT:  alu_out = {31'b0, ($signed(rs_reg) < $signed(op_b))};
      ALU_SLTU: alu_out = {31'b0, (rs_reg < op_b)};
      ALU_LUI:  alu_out = {imm_reg, 16'b0};
      ALU_MFHI: alu_out = hi_reg;
      ALU_MFLO: alu_out = lo_reg;
      default:  alu_out = '0;
    endcase
  end

  assign bypass_exe    = alu_out;
  assign pc_out        = pc_reg;
  assign rt_out        = rt_reg;
  assign rdc_exe       = rdc_reg;
  assign rf_we_out     = rf_we_reg;
  assign exe_rdc_valid = exe_valid_reg && rf_we_reg && !lw_reg;
  assign exe_lw_instr  = exe_valid_reg && lw_reg;
  assign hi_out        = hi_reg;
  assign lo_out        = lo_reg;

  // ---------------------------------------------------------------- divider FSM
  assign div_start = (state_reg == S_IDLE) && exe_valid_reg && is_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush_exe) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (div_start) state_next = S_RUN;
        S_RUN:   if (cnt_reg == 5'd31) state_next = S_DONE;
        S_DONE:  if (mem_allowin) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    exe_ready_go = 1'b1;
    div_busy     = 1'b0;
    if (is_div) begin
      exe_ready_go = (state_reg == S_DONE);
    end
    if ((state_reg == S_RUN) || (state_reg == S_DONE)) begin
      div_busy = 1'b1;
    end
  end

  // ---------------------------------------------------------------- divider datapath
  logic [32:0] shifted;
  logic        step_ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // A zero divisor makes every step succeed, so the quotient fills with ones
  // and the remainder ends up holding the dividend, with no special case.
  assign shifted  = {rem_reg, quo_reg[31]};
  assign step_ge  = shifted >= {1'b0, dvs_reg};
  assign rem_step = step_ge ? (shifted[31:0] - dvs_reg) : shifted[31:0];
  assign quo_step = {quo_reg[30:0], step_ge};

  assign rs_abs  = (div_signed && rs_reg[31]) ? (32'd0 - rs_reg) : rs_reg;
  assign rt_abs  = (div_signed && rt_reg[31]) ? (32'd0 - rt_reg) : rt_reg;
  assign quo_fix = neg_q_reg ? (32'd0 - quo_reg) : quo_reg;
  assign rem_fix = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (div_start && !flush_exe) begin
      cnt_reg   <= '0;
      quo_reg   <= rs_abs;
      rem_reg   <= '0;
      dvs_reg   <= rt_abs;
      neg_q_reg <= div_signed && (rs_reg[31] ^ rt_reg[31]);
      neg_r_reg <= div_signed && rs_reg[31];
    end else if (state_reg == S_RUN) begin
      cnt_reg <= cnt_reg + 5'd1;
      quo_reg <= quo_step;
      rem_reg <= rem_step;
    end
  end

  // HI/LO change only when a finished divide actually leaves for MEM.
  assign hilo_write = (state_reg == S_DONE) && mem_allowin && !flush_exe;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (hilo_write) begin
      hi_reg <= rem_fix;
      lo_reg <= quo_fix;
    end
  end

endmodule

// File: tb/tb_pipe_exe.sv
// Directed bench for pipe_exe: ALU ops, handshake stalls, divides, flush, reset.
`timescale 1ns/1ps

module tb_pipe_exe;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_exe_validto;
  logic        mem_allowin;
  logic        flush_exe;
  logic [31:0] pc_in;
  logic [31:0] rs_in;
  logic [31:0] rt_in;
  logic [15:0] imm_in;
  logic [4:0]  rdc_in;
  logic [3:0]  aluc_in;
  logic        alu_b_sel_in;
  logic        rf_we_in;
  logic        lw_instr_in;
  logic        exe_allowin;
  logic        exe_mem_validto;
  logic [31:0] pc_out;
  logic [31:0] alu_out;
  logic [31:0] rt_out;
  logic [4:0]  rdc_exe;
  logic        rf_we_out;
  logic [31:0] bypass_exe;
  logic        exe_rdc_valid;
  logic        exe_lw_instr;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_exe dut (
    .clk             (clk),
    .rst             (rst),
    .id_exe_validto  (id_exe_validto),
    .mem_allowin     (mem_allowin),
    .flush_exe       (flush_exe),
    .pc_in           (pc_in),
    .rs_in           (rs_in),
    .rt_in           (rt_in),
    .imm_in          (imm_in),
    .rdc_in          (rdc_in),
    .aluc_in         (aluc_in),
    .alu_b_sel_in    (alu_b_sel_in),
    .rf_we_in        (rf_we_in),
    .lw_instr_in     (lw_instr_in),
    .exe_allowin     (exe_allowin),
    .exe_mem_validto (exe_mem_validto),
    .pc_out          (pc_out),
    .alu_out         (alu_out),
    .rt_out          (rt_out),
    .rdc_exe         (rdc_exe),
    .rf_we_out       (rf_we_out),
    .bypass_exe      (bypass_exe),
    .exe_rdc_valid   (exe_rdc_valid),
    .exe_lw_instr    (exe_lw_instr),
    .hi_out          (hi_out),
    .lo_out          (lo_out),
    .div_busy        (div_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] aluc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic bsel,
                       input logic [31:0] pc);
    id_exe_validto = v;
    aluc_in        = aluc;
    rs_in          = rs;
    rt_in          = rt;
    imm_in         = imm;
    alu_b_sel_in   = bsel;
    pc_in          = pc;
    rdc_in         = 5'd3;
    rf_we_in       = 1'b1;
    lw_instr_in    = 1'b0;
  endtask

  // Issue one single-cycle op, then check its result one cycle later.
  task automatic alu_op(input string tag, input logic [3:0] aluc, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input logic bsel,
                        input logic [31:0] exp);
    drive(1'b1, aluc, rs, rt, imm, bsel, 32'h400);
    tick();
    id_exe_validto = 1'b0;
    #1;
    $display("tx %s aluc=%0d rs=%08h rt=%08h imm=%04h -> alu_out=%08h", tag, aluc, rs, rt, imm, alu_out);
    chk(tag, alu_out, exp);
  endtask

  // Run a divide with MFLO waiting in ID; checks stall length, HI/LO and MFLO result.
  task automatic run_div(input string tag, input logic [3:0] aluc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stall;
    drive(1'b1, aluc, rs, rt, 16'h0, 1'b0, 32'h500);
    tick();
    drive(1'b1, 4'd10, 32'h0, 32'h0, 16'h0, 1'b0, 32'h504);
    stall = 0;
    while (exe_allowin === 1'b0 && stall < 40) begin
      stall++;
      tick();
    end
    chk({tag, "_stall"}, stall, 32'd33);
    chk1({tag, "_done_valid"}, exe_mem_validto, 1'b1);
    chk1({tag, "_done_busy"}, div_busy, 1'b1);
    tick();
    id_exe_validto = 1'b0;
    #1;
    $display("tx %s rs=%08h rt=%08h stall=%0d -> hi=%08h lo=%08h", tag, rs, rt, stall, hi_out, lo_out);
    chk({tag, "_hi"}, hi_out, exp_hi);
    chk({tag, "_lo"}, lo_out, exp_lo);
    chk({tag, "_mflo_fwd"}, alu_out, exp_lo);
    chk1({tag, "_busy_after"}, div_busy, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    mem_allowin = 1'b1;
    flush_exe   = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1("rst_allowin", exe_allowin, 1'b1);
    chk1("rst_validto", exe_mem_validto, 1'b0);
    chk1("rst_rdc_valid", exe_rdc_valid, 1'b0);
    chk1("rst_lw", exe_lw_instr, 1'b0);
    chk1("rst_busy", div_busy, 1'b0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);

    // ADDU wrap
    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 32'h100);
    #1;
    chk1("addu_allowin", exe_allowin, 1'b1);
    tick();
    id_exe_validto = 1'b0;
    #1;
    $display("tx addu rs=ffffffff rt=00000001 -> alu_out=%08h", alu_out);
    chk("addu_alu", alu_out, 32'h0);
    chk("addu_bypass", bypass_exe, 32'h0);
    chk1("addu_validto", exe_mem_validto, 1'b1);
    chk1("addu_rdc_valid", exe_rdc_valid, 1'b1);
    chk("addu_pc", pc_out, 32'h100);
    chk("addu_rdc", {27'b0, rdc_exe}, 32'd3);
    tick();
    chk1("empty_validto", exe_mem_validto, 1'b0);

    alu_op("subu", 4'd1, 32'd5, 32'd7, 16'h0, 1'b0, 32'hFFFF_FFFE);
    alu_op("and",  4'd2, 32'h0000_F0F0, 32'h0000_FF00, 16'h0, 1'b0, 32'h0000_F000);
    alu_op("or",   4'd3, 32'h0000_F0F0, 32'h0000_FF00, 16'h0, 1'b0, 32'h0000_FFF0);
    alu_op("xor",  4'd4, 32'h0000_F0F0, 32'h0000_FF00, 16'h0, 1'b0, 32'h0000_0FF0);
    alu_op("nor",  4'd5, 32'h0, 32'hFFFF_0000, 16'h0, 1'b0, 32'h0000_FFFF);
    alu_op("slt",  4'd6, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 32'h1);
    alu_op("sltu", 4'd7, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 32'h0);
    alu_op("addiu_neg", 4'd0, 32'd10, 32'h0, 16'hFFFE, 1'b1, 32'd8);
    alu_op("lui",  4'd8, 32'h0, 32'h0, 16'h1234, 1'b1, 32'h1234_0000);
    alu_op("op13", 4'd13, 32'h5, 32'h6, 16'h0, 1'b0, 32'h0);

    // Load: forwarding must be suppressed, load-use flag raised
    drive(1'b1, 4'd0, 32'h1000, 32'h0, 16'h0004, 1'b1, 32'h180);
    lw_instr_in = 1'b1;
    tick();
    id_exe_validto = 1'b0;
    lw_instr_in    = 1'b0;
    #1;
    $display("tx lw base=00001000 off=0004 -> addr=%08h", alu_out);
    chk("lw_addr", alu_out, 32'h1004);
    chk1("lw_rdc_valid", exe_rdc_valid, 1'b0);
    chk1("lw_flag", exe_lw_instr, 1'b1);
    tick();

    // MEM back-pressure holds the ADDU and blocks the next instruction
    drive(1'b1, 4'd0, 32'd1, 32'd2, 16'h0, 1'b0, 32'h200);
    tick();
    drive(1'b1, 4'd0, 32'd10, 32'd20, 16'h0, 1'b0, 32'h300);
    mem_allowin = 1'b0;
    #1;
    chk1("stall_allowin", exe_allowin, 1'b0);
    chk1("stall_validto", exe_mem_validto, 1'b1);
    tick();
    tick();
    $display("tx stall held pc=%08h alu_out=%08h", pc_out, alu_out);
    chk("stall_pc", pc_out, 32'h200);
    chk("stall_alu", alu_out, 32'd3);
    mem_allowin = 1'b1;
    #1;
    chk1("release_allowin", exe_allowin, 1'b1);
    tick();
    id_exe_validto = 1'b0;
    #1;
    $display("tx release pc=%08h alu_out=%08h", pc_out, alu_out);
    chk("release_pc", pc_out, 32'h300);
    chk("release_alu", alu_out, 32'd30);
    tick();

    // Divides
    run_div("divu_100_7", 4'd12, 32'd100, 32'd7, 32'd2, 32'd14);
    alu_op("mfhi", 4'd9, 32'h0, 32'h0, 16'h0, 1'b0, 32'd2);
    alu_op("mflo", 4'd10, 32'h0, 32'h0, 16'h0, 1'b0, 32'd14);
    run_div("div_m7_2", 4'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_100_m7", 4'd11, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    run_div("divu_5_0", 4'd12, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    tick();

    // Flush during RUN: no HI/LO write, stage empties
    drive(1'b1, 4'd12, 32'd100, 32'd7, 16'h0, 1'b0, 32'h600);
    tick();
    id_exe_validto = 1'b0;
    repeat (10) tick();
    chk1("flush_pre_busy", div_busy, 1'b1);
    flush_exe = 1'b1;
    #1;
    chk1("flush_validto", exe_mem_validto, 1'b0);
    tick();
    flush_exe = 1'b0;
    #1;
    $display("tx flush mid-divide -> allowin=%b busy=%b hi=%08h lo=%08h", exe_allowin, div_busy, hi_out, lo_out);
    chk1("flush_allowin", exe_allowin, 1'b1);
    chk1("flush_busy", div_busy, 1'b0);
    repeat (40) tick();
    chk("flush_hi", hi_out, 32'd5);
    chk("flush_lo", lo_out, 32'hFFFF_FFFF);
    chk1("flush_no_valid", exe_mem_validto, 1'b0);

    // Reset mid-divide
    drive(1'b1, 4'd12, 32'd100, 32'd7, 16'h0, 1'b0, 32'h700);
    tick();
    id_exe_validto = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    $display("tx reset mid-divide -> busy=%b hi=%08h lo=%08h", div_busy, hi_out, lo_out);
    chk("rst2_hi", hi_out, 32'h0);
    chk("rst2_lo", lo_out, 32'h0);
    chk1("rst2_busy", div_busy, 1'b0);
    chk1("rst2_allowin", exe_allowin, 1'b1);
    repeat (40) tick();
    chk("rst2_hi_later", hi_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
